// File: rtl/comp_window_meter_if.sv
// Bundles the comparator inputs, window control and measurement results of
// comp_window_meter; master drives control/comparators, slave is the meter.
interface comp_window_meter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic [N_CH-1:0]       comp_in;
  logic [WIN_W-1:0]      window_len;
  logic                  start;
  logic                  stop;
  logic                  continuous;
  logic [N_CH-1:0]       comp_lvl;
  logic                  busy;
  logic                  res_valid;
  logic [N_CH*CNT_W-1:0] high_cnt;
  logic [N_CH*CNT_W-1:0] edge_cnt;
  logic [N_CH-1:0]       ovf;

  modport master (
    output comp_in, window_len, start, stop, continuous,
    input  comp_lvl, busy, res_valid, high_cnt, edge_cnt, ovf
  );

  modport slave (
    input  comp_in, window_len, start, stop, continuous,
    output comp_lvl, busy, res_valid, high_cnt, edge_cnt, ovf
  );
endinterface

// File: rtl/comp_window_meter.sv
// Multi-channel comparator window meter: synchronise and glitch-filter each
// comparator, then measure per-channel high-time and rising edges per window.
module comp_window_meter #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  comp_window_meter_if.slave  bus
);
  localparam int              FC_W      = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0] FILT_LAST = FC_W'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  logic [SYNC_STAGES-1:0][N_CH-1:0] sync_r;
  logic [N_CH-1:0]                  sync_s;
  logic [N_CH-1:0][FC_W-1:0]        filt_cnt_r;
  logic [N_CH-1:0]                  lvl_r;
  logic [N_CH-1:0]                  lvl_prev_r;
  logic [N_CH-1:0]                  rise_s;

  state_t                           state_r;
  logic [WIN_W-1:0]                 win_len_r;
  logic [WIN_W-1:0]                 win_cnt_r;
  logic                             cont_r;
  logic                             win_end_s;
  logic [N_CH-1:0][CNT_W-1:0]       high_acc_r;
  logic [N_CH-1:0][CNT_W-1:0]       edge_acc_r;
  logic [N_CH-1:0][CNT_W-1:0]       high_nxt_s;
  logic [N_CH-1:0][CNT_W-1:0]       edge_nxt_s;
  logic [N_CH-1:0][CNT_W-1:0]       high_res_r;
  logic [N_CH-1:0][CNT_W-1:0]       edge_res_r;
  logic [N_CH-1:0]                  ovf_acc_r;
  logic [N_CH-1:0]                  ovf_nxt_s;
  logic [N_CH-1:0]                  ovf_r;
  logic                             res_valid_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
    if (inc && (cnt != CNT_MAX)) return cnt + CNT_W'(1);
    else return cnt;
  endfunction

  function automatic logic sat_hit(input logic [CNT_W-1:0] cnt, input logic inc);
    return inc && (cnt == CNT_MAX);
  endfunction

  assign sync_s    = sync_r[SYNC_STAGES-1];
  assign rise_s    = lvl_r & ~lvl_prev_r;
  assign win_end_s = (win_cnt_r == (win_len_r - WIN_W'(1)));

  // Synchroniser chain for the asynchronous comparator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.comp_in};
    end
  end

  // Glitch filter: level flips only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_r <= '0;
      lvl_r      <= '0;
      lvl_prev_r <= '0;
    end else begin
      lvl_prev_r <= lvl_r;
      for (int c = 0; c < N_CH; c++) begin
        if (sync_s[c] == lvl_r[c]) begin
          filt_cnt_r[c] <= '0;
        end else if (filt_cnt_r[c] == FILT_LAST) begin
          filt_cnt_r[c] <= '0;
          lvl_r[c]      <= ~lvl_r[c];
        end else begin
          filt_cnt_r[c] <= filt_cnt_r[c] + FC_W'(1);
        end
      end
    end
  end

  // Next accumulator values with saturation and sticky overflow
  always_comb begin
    high_nxt_s = high_acc_r;
    edge_nxt_s = edge_acc_r;
    ovf_nxt_s  = ovf_acc_r;
    for (int c = 0; c < N_CH; c++) begin
      high_nxt_s[c] = sat_inc(high_acc_r[c], lvl_r[c]);
      edge_nxt_s[c] = sat_inc(edge_acc_r[c], rise_s[c]);
      ovf_nxt_s[c]  = ovf_acc_r[c] | sat_hit(high_acc_r[c], lvl_r[c])
                                   | sat_hit(edge_acc_r[c], rise_s[c]);
    end
  end

  // Window FSM: accumulate in RUN, publish results at window end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      win_len_r   <= '0;
      win_cnt_r   <= '0;
      cont_r      <= 1'b0;
      high_acc_r  <= '0;
      edge_acc_r  <= '0;
      ovf_acc_r   <= '0;
      high_res_r  <= '0;
      edge_res_r  <= '0;
      ovf_r       <= '0;
      res_valid_r <= 1'b0;
    end else begin
      res_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state_r    <= RUN;
            win_len_r  <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
            cont_r     <= bus.continuous;
            win_cnt_r  <= '0;
            high_acc_r <= '0;
            edge_acc_r <= '0;
            ovf_acc_r  <= '0;
          end
        end
        RUN: begin
          // stop wins over window end, so an aborted window never publishes
          if (bus.stop) begin
            state_r <= IDLE;
          end else if (win_end_s) begin
            high_res_r  <= high_nxt_s;
            edge_res_r  <= edge_nxt_s;
            ovf_r       <= ovf_nxt_s;
            res_valid_r <= 1'b1;
            high_acc_r  <= '0;
            edge_acc_r  <= '0;
            ovf_acc_r   <= '0;
            win_cnt_r   <= '0;
            state_r     <= cont_r ? RUN : IDLE;
          end else begin
            high_acc_r <= high_nxt_s;
            edge_acc_r <= edge_nxt_s;
            ovf_acc_r  <= ovf_nxt_s;
            win_cnt_r  <= win_cnt_r + WIN_W'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.comp_lvl  = lvl_r;
  assign bus.busy      = (state_r == RUN);
  assign bus.res_valid = res_valid_r;
  assign bus.high_cnt  = high_res_r;
  assign bus.edge_cnt  = edge_res_r;
  assign bus.ovf       = ovf_r;
endmodule
